// File: rtl/pipe_iram_loader_pkg.sv
// Shared definitions for the instruction-RAM loader and the fetch-stage RAM.
package pipe_iram_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int IRAM_ADDR_W    = 5;
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/pipe_byte_packer.sv
// Packs host bytes little-endian into a 32-bit word; word_full flags the accept
// that completes the word.
module pipe_byte_packer
  import pipe_iram_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_accept,
  input  logic [7:0]        i_byte,
  output logic [WORD_W-1:0] o_word,
  output logic              o_word_full
);

  logic [1:0]        r_byte_cnt;
  logic [WORD_W-1:0] r_word;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_byte_cnt <= 2'd0;
      r_word     <= '0;
    end else if (i_clear) begin
      r_byte_cnt <= 2'd0;
      r_word     <= '0;
    end else if (i_accept) begin
      // Counter wraps to 0 after the 4th byte, ready for the next word.
      r_word[{r_byte_cnt, 3'b000} +: 8] <= i_byte;
      r_byte_cnt                        <= r_byte_cnt + 2'd1;
    end
  end

  assign o_word      = r_word;
  assign o_word_full = i_accept && (r_byte_cnt == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/pipe_iram_loader.sv
// Loads a host byte stream into instruction RAM word by word, holding the CPU
// pipeline for the whole session.
// Byte handshake: a byte transfers on a rising edge where byte_valid & byte_ready;
// the host keeps byte_data stable while byte_valid=1 and byte_ready=0.
module pipe_iram_loader
  import pipe_iram_loader_pkg::*;
#(
  parameter int ADDR_W = IRAM_ADDR_W,
  parameter int LEN_W  = ADDR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  len_words,
  input  logic              abort,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              ram_ena,
  output logic              ram_wena,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [31:0]       load_pc,
  output logic [31:0]       ram_indata,
  output logic              cpu_hold,
  output logic              done,
  output logic [1:0]        dbg_state
);

  localparam int DEPTH = 1 << ADDR_W;

  state_e             r_state;
  logic [ADDR_W-1:0]  r_word_cnt;
  logic [LEN_W-1:0]   r_len;

  logic               w_accept;
  logic               w_clear;
  logic               w_word_full;
  logic               w_last;
  logic [WORD_W-1:0]  w_word;
  logic [LEN_W-1:0]   w_len_clamped;

  // Clamping the length keeps the word address from ever wrapping.
  assign w_len_clamped = (len_words > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : len_words;
  assign w_last        = (LEN_W'(r_word_cnt) == (r_len - LEN_W'(1)));

  assign byte_ready = (r_state == ST_COLLECT);
  assign w_accept   = byte_valid & byte_ready;
  assign w_clear    = (r_state == ST_IDLE) | abort;

  pipe_byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_clear),
    .i_accept   (w_accept),
    .i_byte     (byte_data),
    .o_word     (w_word),
    .o_word_full(w_word_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_word_cnt <= '0;
      r_len      <= '0;
    end else if (abort && (r_state != ST_IDLE)) begin
      r_state    <= ST_IDLE;
      r_word_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_len      <= w_len_clamped;
            r_word_cnt <= '0;
            r_state    <= (w_len_clamped == '0) ? ST_DONE : ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (w_word_full) r_state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (w_last) begin
            r_state <= ST_DONE;
          end else begin
            r_word_cnt <= r_word_cnt + 1'b1;
            r_state    <= ST_COLLECT;
          end
        end
        default: begin
          r_state    <= ST_IDLE;
          r_word_cnt <= '0;
        end
      endcase
    end
  end

  // A same-cycle abort suppresses the write so no word lands after cancel.
  assign ram_ena    = (r_state == ST_WRITE) & ~abort;
  assign ram_wena   = (r_state == ST_WRITE) & ~abort;
  assign ram_addr   = r_word_cnt;
  assign load_pc    = {{(30 - ADDR_W){1'b0}}, r_word_cnt, 2'b00};
  assign ram_indata = w_word;
  assign cpu_hold   = (r_state != ST_IDLE);
  assign done       = (r_state == ST_DONE);
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_pipe_iram_loader.sv
// Bench for pipe_iram_loader: table-driven sessions, random sessions and
// hand-written corner sequences, all checked against a write-log model.
module tb_pipe_iram_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [5:0]  len_words;
  logic        abort;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        ram_ena;
  logic        ram_wena;
  logic [4:0]  ram_addr;
  logic [31:0] load_pc;
  logic [31:0] ram_indata;
  logic        cpu_hold;
  logic        done;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;
  int done_cnt = 0;
  logic [31:0] last_pc = '0;
  logic [36:0] exp_q[$];
  logic [36:0] e;
  logic [31:0] words[64];

  typedef struct {
    logic [5:0] len;
    int         exp_writes;
    int         gmax;
    int         mode;
  } vec_t;
  vec_t vt[7];

  pipe_iram_loader dut (
    .clk(clk), .rst(rst), .start(start), .len_words(len_words), .abort(abort),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .ram_ena(ram_ena), .ram_wena(ram_wena), .ram_addr(ram_addr), .load_pc(load_pc),
    .ram_indata(ram_indata), .cpu_hold(cpu_hold), .done(done), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Write monitor: every RAM write must match the next expected {addr, data}.
  always @(negedge clk) begin
    if (!rst && ram_wena) begin
      wr_cnt++;
      last_pc = load_pc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_write: addr=%0d data=%h expected no write", ram_addr, ram_indata);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 64'(ram_addr), 64'(e[36:32]));
        chk("wr_data", 64'(ram_indata), 64'(e[31:0]));
        chk("wr_pc", 64'(load_pc), 64'({e[36:32], 2'b00}));
        chk("wr_ena", 64'(ram_ena), 64'(1));
      end
    end
    if (!rst && done) done_cnt++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  got;
    byte_valid = 1'b1;
    byte_data  = b;
    got = 1'b0;
    n   = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      got = byte_ready;
      tick();
      n++;
    end
    byte_valid = 1'b0;
    if (!got) begin
      total++;
      bad++;
      $display("FAIL send_timeout: byte %h accepted=0 expected 1", b);
    end
  endtask

  task automatic pulse_start(input logic [5:0] len);
    start     = 1'b1;
    len_words = len;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 64'({byte_ready, ram_ena, ram_wena, ram_addr, cpu_hold, done}), 64'(0));
    chk({name, "_data"}, {load_pc, ram_indata}, 64'(0));
  endtask

  // Reference: a session of len words writes min(len,32) words at 0,1,2,...
  task automatic run_session(input logic [5:0] len, input int exp_n, input int gmax, input int mode);
    int n, d0, w0;
    n  = (int'(len) > 32) ? 32 : int'(len);
    d0 = done_cnt;
    w0 = wr_cnt;
    for (int k = 0; k < n; k++) begin
      words[k] = (mode == 1) ? (32'hA000_0000 + 32'(k)) : $urandom;
      exp_q.push_back({5'(k), words[k]});
    end
    pulse_start(len);
    for (int k = 0; k < n; k++) begin
      for (int b = 0; b < 4; b++) begin
        repeat ($urandom_range(0, gmax)) tick();
        send_byte(words[k][8*b +: 8]);
      end
    end
    repeat (4) tick();
    @(negedge clk);
    chk("sess_hold", 64'(cpu_hold), 64'(0));
    chk("sess_writes", 64'(wr_cnt - w0), 64'(exp_n));
    chk("sess_done", 64'(done_cnt - d0), 64'(1));
    chk("sess_pending", 64'(exp_q.size()), 64'(0));
    exp_q.delete();
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, w0;
    vt[0] = '{len: 6'd1,  exp_writes: 1,  gmax: 0, mode: 0};
    vt[1] = '{len: 6'd0,  exp_writes: 0,  gmax: 0, mode: 0};
    vt[2] = '{len: 6'd32, exp_writes: 32, gmax: 3, mode: 1};
    vt[3] = '{len: 6'd40, exp_writes: 32, gmax: 0, mode: 1};
    vt[4] = '{len: 6'd63, exp_writes: 32, gmax: 1, mode: 0};
    vt[5] = '{len: 6'd3,  exp_writes: 3,  gmax: 2, mode: 0};
    vt[6] = '{len: 6'd2,  exp_writes: 2,  gmax: 0, mode: 0};

    rst = 1'b1; start = 1'b0; len_words = '0; abort = 1'b0;
    byte_valid = 1'b0; byte_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_all_zero("idle");
    end
    tick();

    // Single word, back-to-back bytes, exact write/done timing.
    exp_q.push_back({5'd0, 32'h2010_0013});
    pulse_start(6'd1);
    send_byte(8'h13); send_byte(8'h00); send_byte(8'h10); send_byte(8'h20);
    @(negedge clk);
    chk("sw_wena", 64'(ram_wena), 64'(1));
    chk("sw_data", 64'(ram_indata), 64'h2010_0013);
    @(negedge clk);
    chk("sw_done", 64'({done, cpu_hold}), 64'(2'b11));
    @(negedge clk);
    chk("sw_after", 64'({done, cpu_hold}), 64'(0));
    tick();

    // Zero length: done on the cycle after start, no write.
    pulse_start(6'd0);
    @(negedge clk);
    chk("len0_done", 64'(done), 64'(1));
    @(negedge clk);
    chk("len0_after", 64'({done, cpu_hold}), 64'(0));
    tick();

    for (int i = 0; i < 7; i++) begin
      run_session(vt[i].len, vt[i].exp_writes, vt[i].gmax, vt[i].mode);
      if (vt[i].exp_writes == 32) chk("last_pc", 64'(last_pc), 64'h7C);
    end

    // Abort after word 0 plus two bytes of word 1.
    d0 = done_cnt; w0 = wr_cnt;
    words[0] = $urandom;
    exp_q.push_back({5'd0, words[0]});
    pulse_start(6'd4);
    for (int b = 0; b < 4; b++) send_byte(words[0][8*b +: 8]);
    send_byte(8'h5A); send_byte(8'hA5);
    abort = 1'b1;
    @(negedge clk);
    chk("ab_wena", 64'(ram_wena), 64'(0));
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("ab_state", 64'({cpu_hold, done, dbg_state}), 64'(0));
    repeat (5) tick();
    chk("ab_done", 64'(done_cnt - d0), 64'(0));
    chk("ab_writes", 64'(wr_cnt - w0), 64'(1));
    exp_q.delete();
    run_session(6'd1, 1, 0, 0);

    // Abort landing on the WRITE cycle suppresses that write.
    pulse_start(6'd2);
    for (int b = 0; b < 4; b++) send_byte(8'(b + 1));
    abort = 1'b1;
    @(negedge clk);
    chk("abw_ena", 64'({ram_ena, ram_wena}), 64'(0));
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abw_hold", 64'(cpu_hold), 64'(0));
    tick();

    // start together with abort in IDLE is ignored.
    start = 1'b1; abort = 1'b1; len_words = 6'd3;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort", 64'({cpu_hold, dbg_state}), 64'(0));
    tick();

    // Backpressure: byte held valid across the WRITE cycle is taken once.
    words[0] = 32'h4433_2211;
    words[1] = 32'h8877_6655;
    exp_q.push_back({5'd0, words[0]});
    exp_q.push_back({5'd1, words[1]});
    d0 = done_cnt;
    pulse_start(6'd2);
    for (int b = 0; b < 4; b++) send_byte(words[0][8*b +: 8]);
    byte_valid = 1'b1;
    byte_data  = words[1][7:0];
    @(negedge clk);
    chk("bp_ready", 64'({byte_ready, ram_wena}), 64'(2'b01));
    for (int b = 0; b < 4; b++) send_byte(words[1][8*b +: 8]);
    repeat (3) tick();
    chk("bp_done", 64'(done_cnt - d0), 64'(1));
    chk("bp_pending", 64'(exp_q.size()), 64'(0));
    exp_q.delete();

    // Random sessions.
    for (int i = 0; i < 6; i++) begin
      logic [5:0] l;
      l = 6'($urandom_range(0, 40));
      run_session(l, (int'(l) > 32) ? 32 : int'(l), $urandom_range(0, 2), 0);
    end

    // Asynchronous reset mid-session clears everything immediately.
    pulse_start(6'd2);
    send_byte(8'hDE); send_byte(8'hAD);
    #2 rst = 1'b1;
    #1;
    chk_all_zero("async_rst");
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk_all_zero("post_rst");
    tick();
    run_session(6'd2, 2, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_iram_loader.md
Name: pipe_iram_loader

Overview:
Writer side of the instruction-RAM programming interface. It takes a byte stream from a host link (UART/debug bridge) and packs it into 32-bit instruction words. It writes those words sequentially into the fetch stage's instruction RAM through the ram_ena/ram_wena/ram_indata write path. While loading, it holds the CPU pipeline, so fetch never reads a partially written program.

Parameters:
ADDR_W, 5, word-address width of instruction RAM (depth 2^ADDR_W = 32 words)
LEN_W, 6, width of length input (ADDR_W+1, so a full-depth count is representable)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle pulse; begins a load session (ignored unless IDLE)
len_words  in  LEN_W  number of words to load; latched on start
abort  in  1  cancels the session; returns to IDLE
byte_valid  in  1  host byte present
byte_data  in  8  host byte
byte_ready  out  1  loader accepts byte this cycle (transfer = valid & ready)
ram_ena  out  1  instruction RAM enable (write cycles only)
ram_wena  out  1  instruction RAM write enable
ram_addr  out  ADDR_W  word address; top-level muxes it onto pc[6:2] while cpu_hold=1
load_pc  out  32  {zeros, ram_addr, 2'b00}; convenience byte-address form
ram_indata  out  32  assembled instruction word
cpu_hold  out  1  stall/hold PC and pipeline
done  out  1  one-cycle pulse at successful completion

Behaviour:
- Reset (async, rst=1): state IDLE. All outputs 0: byte_ready, ram_ena, ram_wena, ram_addr, load_pc, ram_indata, cpu_hold, done. Byte and word counters are cleared.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE:
  - start=1 latches len_words. Values above 2^ADDR_W clamp to 2^ADDR_W.
  - If the latched length is 0, go to DONE. Otherwise go to COLLECT with word_cnt=0 and byte_cnt=0.
  - cpu_hold rises the cycle after start.
- COLLECT:
  - byte_ready=1.
  - On each transfer, the byte goes into lane byte_cnt, little-endian: first byte lands in [7:0], fourth in [31:24]. byte_cnt then increments.
  - The 4th transfer goes to WRITE. No gaps are needed between bytes, so one byte per cycle is sustained.
- WRITE, exactly one cycle:
  - byte_ready=0; ram_ena=ram_wena=1; ram_addr=word_cnt; ram_indata = the assembled word.
  - Next state: if word_cnt == len-1, go to DONE. Otherwise word_cnt++, byte_cnt=0, go to COLLECT.
  - Latency: last byte accepted -> RAM write on the next cycle.
- DONE, one cycle: done=1, cpu_hold=1, then IDLE with cpu_hold=0. The CPU resumes the cycle after done.
- ram_addr holds the current word_cnt in COLLECT/WRITE and returns to 0 in IDLE. load_pc always mirrors ram_addr.
- ram_ena/ram_wena are never asserted outside WRITE.
- abort (any non-IDLE state):
  - Next state is IDLE, with cpu_hold=0 and done=0.
  - A partial word is discarded; no write occurs. Words already written stay in RAM.
  - abort takes priority over a same-cycle WRITE, which is suppressed.
- start outside IDLE is ignored. start and abort together in IDLE: abort wins, so the loader stays IDLE.
- byte_valid while byte_ready=0: the byte is not consumed, and the host must hold it.
- Address wrap: never occurs, because of the length clamp. The final word index is 2^ADDR_W-1.
- Async reset mid-session: immediate IDLE with all outputs 0. RAM contents are undefined for the interrupted word only.

Decomposition:
- Shared package/header:
  - State encodings (2-bit: IDLE=0, COLLECT=1, WRITE=2, DONE=3).
  - BYTES_PER_WORD=4.
  - IRAM_ADDR_W=5, shared with the fetch stage's RAM instance.
- One natural sub-module: pipe_byte_packer. It holds the byte_cnt counter and the 32-bit lane register, with clear and accept inputs and a word_full output. The FSM and word counter stay in the top.

Test Plan:
- Reset then idle: rst=1 mid-operation -> next edge all outputs 0. rst released with no start -> outputs stay 0 for 10 cycles.
- Single word: start, len=1, bytes 0x13,0x00,0x10,0x20 back-to-back -> one WRITE cycle with ram_addr=0, ram_indata=0x20100013, ram_wena=1. done pulses the next cycle, and cpu_hold falls after it.
- Full depth with valid gaps: len=32, random byte_valid gaps, word k = 0xA0000000+k -> exactly 32 writes at addresses 0..31 with matching data. load_pc on the final write = 0x7C. No write to any address beyond 31.
- Length edge cases: len=0 -> no write; done one cycle after start. len=40 -> clamped to 32 writes.
- Abort mid-word: len=4; after word 0 plus 2 bytes of word 1, assert abort -> no further ram_wena, IDLE, cpu_hold=0, done never asserted. A new start then reloads from address 0.
- Backpressure: hold byte_valid=1 through the WRITE cycle -> byte_ready=0 there, and the byte is accepted exactly once in the following COLLECT cycle with no duplication.
